// File: rtl/ccff_chain_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ccff_chain_loader                                                |
// | Brief   : Head-end configuration-chain loader with tail readback capture.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8,
  localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              chain_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] c_TOT_LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WORD_W-1:0]  r_tx;
  logic [WORD_W-1:0]  r_rb_shreg;
  logic [WORD_W-1:0]  r_rb_data;
  logic               r_rb_valid;
  logic [BIT_W-1:0]   r_bitcnt;
  logic [CNT_W-1:0]   r_total;
  logic [WORD_W-1:0]  w_rb_next;
  logic               w_cfg_ready;
  logic               w_chain_en;
  logic               w_head;
  logic               w_last;

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_ready = 1'b0;
    w_chain_en  = 1'b0;
    w_head      = 1'b0;
    w_last      = 1'b0;
    // Capture register is cleared per word, so a short final word leaves upper bits 0.
    w_rb_next           = r_rb_shreg;
    w_rb_next[r_bitcnt] = ccff_tail;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_cfg_ready = 1'b1;
        if (cfg_valid) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_chain_en = 1'b1;
        w_head     = r_tx[0];
        if ((r_bitcnt == c_BIT_LAST) || (r_total == c_TOT_LAST)) begin
          w_last      = 1'b1;
          w_state_nxt = (r_total == c_TOT_LAST) ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state    <= S_IDLE;
      r_tx       <= '0;
      r_rb_shreg <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
      r_bitcnt   <= '0;
      r_total    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) r_total <= '0;
        end
        S_LOAD: begin
          if (cfg_valid) begin
            r_tx       <= cfg_data;
            r_bitcnt   <= '0;
            r_rb_shreg <= '0;
          end
        end
        S_SHIFT: begin
          r_tx       <= r_tx >> 1;
          r_bitcnt   <= r_bitcnt + 1'b1;
          r_total    <= r_total + 1'b1;
          r_rb_shreg <= w_rb_next;
          if (w_last) begin
            r_rb_data  <= w_rb_next;
            r_rb_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cfg_ready = w_cfg_ready;
  assign chain_en  = w_chain_en;
  assign ccff_head = w_head;
  assign rb_data   = r_rb_data;
  assign rb_valid  = r_rb_valid;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ccff_chain_loader                                             |
// | Brief   : Scoreboard bench; two loaders (16/8 and 12/8) on modelled chains.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ccff_chain_loader;

  logic       prog_clk = 1'b0;
  logic       prog_reset;
  logic       start     [2];
  logic [7:0] cfg_data  [2];
  logic       cfg_valid [2];
  logic       cfg_ready [2];
  logic       ccff_head [2];
  logic       chain_en  [2];
  logic       ccff_tail [2];
  logic [7:0] rb_data   [2];
  logic       rb_valid  [2];
  logic       busy      [2];
  logic       done      [2];

  logic [15:0] ch_a = '0;
  logic [11:0] ch_b = '1;

  int checks = 0;
  int errors = 0;
  int en_cnt   [2] = '{0, 0};
  int runs     [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  logic prev_en [2] = '{1'b0, 1'b0};
  logic [7:0] sb[$];
  logic       head_q[$];

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_dut_a (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start[0]),
    .cfg_data(cfg_data[0]), .cfg_valid(cfg_valid[0]), .cfg_ready(cfg_ready[0]),
    .ccff_head(ccff_head[0]), .chain_en(chain_en[0]), .ccff_tail(ccff_tail[0]),
    .rb_data(rb_data[0]), .rb_valid(rb_valid[0]), .busy(busy[0]), .done(done[0])
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_dut_b (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start[1]),
    .cfg_data(cfg_data[1]), .cfg_valid(cfg_valid[1]), .cfg_ready(cfg_ready[1]),
    .ccff_head(ccff_head[1]), .chain_en(chain_en[1]), .ccff_tail(ccff_tail[1]),
    .rb_data(rb_data[1]), .rb_valid(rb_valid[1]), .busy(busy[1]), .done(done[1])
  );

  // Fabric chain: index 0 is next to the head, the top index drives the tail.
  assign ccff_tail[0] = ch_a[15];
  assign ccff_tail[1] = ch_b[11];
  always @(posedge prog_clk) begin
    if (chain_en[0]) ch_a <= {ch_a[14:0], ccff_head[0]};
    if (chain_en[1]) ch_b <= {ch_b[10:0], ccff_head[1]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge prog_clk) begin
    for (int d = 0; d < 2; d++) begin
      if (chain_en[d]) begin
        en_cnt[d]++;
        head_q.push_back(ccff_head[d]);
        if (!prev_en[d]) runs[d]++;
      end
      prev_en[d] = chain_en[d];
      if (rb_valid[d]) begin
        if (sb.size() == 0) check_eq("rb_unexpected", 1, 0);
        else check_eq("rb_data", {24'd0, rb_data[d]}, {24'd0, sb.pop_front()});
      end
      if (done[d]) begin
        done_cnt[d]++;
        check_eq("done_with_rbv", {31'd0, rb_valid[d]}, 1);
      end
    end
  end

  // One full load. With use_model the readback expectations come from the chain model snapshot.
  task automatic do_load(input int d, input logic [7:0] w0, input logic [7:0] w1,
                         input int len, input logic [7:0] e0, input logic [7:0] e1,
                         input bit use_model, input bit bp, input bit pulse);
    int en0, run0, dn0, h0, n, nw;
    logic [7:0] w [2];
    logic [7:0] e [2];
    w[0] = w0; w[1] = w1;
    e[0] = e0; e[1] = e1;
    nw = (len + 7) / 8;
    if (use_model) begin
      for (int k = 0; k < 2; k++) begin
        e[k] = '0;
        for (int j = 0; j < 8; j++)
          if (k * 8 + j < 16) e[k][j] = ch_a[15 - (k * 8 + j)];
      end
    end
    for (int k = 0; k < nw; k++) sb.push_back(e[k]);
    en0 = en_cnt[d]; run0 = runs[d]; dn0 = done_cnt[d]; h0 = head_q.size();
    start[d] = 1'b1;
    @(negedge prog_clk);
    start[d] = 1'b0;
    check_eq("ready_after_start", {31'd0, cfg_ready[d]}, 1);
    if (bp) begin
      repeat (5) begin
        @(negedge prog_clk);
        check_eq("bp_ready", {31'd0, cfg_ready[d]}, 1);
        check_eq("bp_chain_en", {31'd0, chain_en[d]}, 0);
        check_eq("bp_busy", {31'd0, busy[d]}, 1);
      end
    end
    for (int k = 0; k < nw; k++) begin
      cfg_data[d]  = w[k];
      cfg_valid[d] = 1'b1;
      n = 0;
      while (!cfg_ready[d] && n < 40) begin
        @(negedge prog_clk);
        n++;
      end
      if (n >= 40) check_eq("accept_timeout", n, 0);
      @(negedge prog_clk);
      if (pulse && k == 0) begin
        start[d] = 1'b1;
        @(negedge prog_clk);
        start[d] = 1'b0;
      end
    end
    cfg_valid[d] = 1'b0;
    n = 0;
    while (done_cnt[d] == dn0 && n < 60) begin
      @(negedge prog_clk);
      n++;
    end
    repeat (3) @(negedge prog_clk);
    check_eq("done_count", done_cnt[d] - dn0, 1);
    check_eq("en_cycles", en_cnt[d] - en0, len);
    check_eq("en_runs", runs[d] - run0, nw);
    check_eq("sb_drained", sb.size(), 0);
    check_eq("idle_after", {31'd0, busy[d]}, 0);
    if (head_q.size() >= h0 + len) begin
      for (int i = 0; i < len; i++)
        check_eq($sformatf("head_bit%0d", i), {31'd0, head_q[h0 + i]}, {31'd0, w[i / 8][i % 8]});
    end else begin
      check_eq("head_len", head_q.size() - h0, len);
    end
    sb.delete();
  endtask

  initial begin
    int dn0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; cfg_data[d] = '0; cfg_valid[d] = 1'b0;
    end
    prog_reset = 1'b1;
    start[0]   = 1'b1;
    repeat (2) @(negedge prog_clk);
    start[0]   = 1'b0;
    prog_reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_busy", {31'd0, busy[d]}, 0);
      check_eq("rst_ready", {31'd0, cfg_ready[d]}, 0);
      check_eq("rst_chain_en", {31'd0, chain_en[d]}, 0);
      check_eq("rst_head", {31'd0, ccff_head[d]}, 0);
      check_eq("rst_rb_valid", {31'd0, rb_valid[d]}, 0);
      check_eq("rst_done", {31'd0, done[d]}, 0);
      check_eq("rst_rb_data", {24'd0, rb_data[d]}, 0);
    end
    @(negedge prog_clk);
    check_eq("start_during_reset_ignored", {31'd0, busy[0]}, 0);

    do_load(0, 8'hA5, 8'h3C, 16, 8'h00, 8'h00, 0, 0, 0);
    do_load(0, 8'h11, 8'h22, 16, 8'hA5, 8'h3C, 0, 0, 0);
    do_load(1, 8'hFF, 8'hFF, 12, 8'hFF, 8'h0F, 0, 0, 0);
    do_load(0, 8'hA5, 8'h3C, 16, 8'h11, 8'h22, 0, 1, 0);

    // Reset during the third shift cycle of the first word.
    dn0 = done_cnt[0];
    start[0] = 1'b1;
    @(negedge prog_clk);
    start[0]     = 1'b0;
    cfg_data[0]  = 8'hA5;
    cfg_valid[0] = 1'b1;
    @(negedge prog_clk);
    cfg_valid[0] = 1'b0;
    repeat (2) @(negedge prog_clk);
    check_eq("pre_rst_chain_en", {31'd0, chain_en[0]}, 1);
    prog_reset = 1'b1;
    @(negedge prog_clk);
    prog_reset = 1'b0;
    check_eq("midrst_busy", {31'd0, busy[0]}, 0);
    check_eq("midrst_chain_en", {31'd0, chain_en[0]}, 0);
    check_eq("midrst_ready", {31'd0, cfg_ready[0]}, 0);
    check_eq("midrst_head", {31'd0, ccff_head[0]}, 0);
    check_eq("midrst_rb_valid", {31'd0, rb_valid[0]}, 0);
    check_eq("midrst_rb_data", {24'd0, rb_data[0]}, 0);
    repeat (4) @(negedge prog_clk);
    check_eq("midrst_no_done", done_cnt[0] - dn0, 0);

    do_load(0, 8'h5A, 8'hC3, 16, 8'h00, 8'h00, 1, 0, 0);
    do_load(0, 8'h11, 8'h22, 16, 8'h5A, 8'hC3, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
